seq_mult_signed: RTL and testbench



---
 rtl/seq_mult_signed_pkg.sv | 24 ++
 rtl/seq_mult_signed_if.sv | 22 ++
 rtl/seq_mult_signed_cond_negate.sv | 15 +
 rtl/seq_mult_signed.sv | 127 ++++++++++++
 tb/tb_seq_mult_signed.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_mult_signed_pkg.sv
// Shared definitions for the sequential signed/unsigned multiplier:
// FSM state encoding and a ceiling-log2 helper for sizing the bit counter.
package seq_mult_signed_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_mult_signed_if.sv
// Start/done handshake and operand/result bus of the sequential multiplier.
interface seq_mult_signed_if #(
  parameter int SIZE = 16
);
  logic                iStart;
  logic                iSigned;
  logic [SIZE-1:0]     iMulA;
  logic [SIZE-1:0]     iMulB;
  logic                oBusy;
  logic                oDone;
  logic [2*SIZE-1:0]   oMulR;

  modport master (
    output iStart, iSigned, iMulA, iMulB,
    input  oBusy, oDone, oMulR
  );

  modport slave (
    input  iStart, iSigned, iMulA, iMulB,
    output oBusy, oDone, oMulR
  );
endinterface

// File: rtl/seq_mult_signed_cond_negate.sv
// Combinational conditional two's-complement negation: oVal = iNeg ? -iVal : iVal.
module cond_negate #(
  parameter int W = 16
) (
  input  logic [W-1:0] iVal,
  input  logic         iNeg,
  output logic [W-1:0] oVal
);

  logic [W-1:0] w_negated;

  assign w_negated = (~iVal) + {{(W-1){1'b0}}, 1'b1};
  assign oVal      = iNeg ? w_negated : iVal;

endmodule

// File: rtl/seq_mult_signed.sv
// Radix-2 shift-add multiplier: one SIZE+1-bit adder reused over SIZE cycles,
// operands reduced to magnitudes on accept and the sign re-applied in FIX.
module seq_mult_signed
  import seq_mult_signed_pkg::*;
#(
  parameter int SIZE = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  seq_mult_signed_if.slave bus
);

  localparam int                CNT_W    = clog2(SIZE) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SIZE - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic [2*SIZE-1:0]   r_acc;
  logic [2*SIZE-1:0]   r_mulr;
  logic [SIZE-1:0]     r_mag_a;
  logic [SIZE-1:0]     r_mul_b;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_neg;
  logic                r_busy;
  logic                r_done;
  logic [SIZE-1:0]     w_mag_a;
  logic [SIZE-1:0]     w_mag_b;
  logic [SIZE:0]       w_sum;
  logic [2*SIZE-1:0]   w_fixed;

  cond_negate #(.W(SIZE)) u_neg_a (
    .iVal (bus.iMulA),
    .iNeg (bus.iSigned & bus.iMulA[SIZE-1]),
    .oVal (w_mag_a)
  );

  cond_negate #(.W(SIZE)) u_neg_b (
    .iVal (bus.iMulB),
    .iNeg (bus.iSigned & bus.iMulB[SIZE-1]),
    .oVal (w_mag_b)
  );

  cond_negate #(.W(2*SIZE)) u_fix (
    .iVal (r_acc),
    .iNeg (r_neg),
    .oVal (w_fixed)
  );

  // Upper accumulator half plus the partial product, carry kept in the MSB
  assign w_sum = {1'b0, r_acc[2*SIZE-1:SIZE]} +
                 (r_mul_b[0] ? {1'b0, r_mag_a} : {(SIZE+1){1'b0}});

  // Next-state decode; starts are only honoured from IDLE and DONE
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.iStart) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_CALC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_FIX;
        end else begin
          w_state_nxt = ST_CALC;
        end
      end
      ST_FIX:  w_state_nxt = ST_DONE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_acc   <= {(2*SIZE){1'b0}};
      r_mulr  <= {(2*SIZE){1'b0}};
      r_mag_a <= {SIZE{1'b0}};
      r_mul_b <= {SIZE{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
      r_neg   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == ST_CALC) || (w_state_nxt == ST_FIX);
      r_done <= (w_state_nxt == ST_DONE);
      if (w_accept) begin
        r_mag_a <= w_mag_a;
        r_mul_b <= w_mag_b;
        r_neg   <= bus.iSigned & (bus.iMulA[SIZE-1] ^ bus.iMulB[SIZE-1]);
        r_acc   <= {(2*SIZE){1'b0}};
        r_cnt   <= {CNT_W{1'b0}};
      end else if (r_state == ST_CALC) begin
        r_acc   <= {w_sum, r_acc[SIZE-1:1]};
        r_mul_b <= r_mul_b >> 1;
        r_cnt   <= r_cnt + CNT_W'(1);
      end else begin
        r_acc   <= r_acc;
      end
      if (r_state == ST_FIX) begin
        r_mulr <= w_fixed;
      end else begin
        r_mulr <= r_mulr;
      end
    end
  end

  assign bus.oBusy = r_busy;
  assign bus.oDone = r_done;
  assign bus.oMulR = r_mulr;

endmodule

// File: tb/tb_seq_mult_signed.sv
// Directed-vector bench for seq_mult_signed at SIZE=16 and SIZE=8.
module tb_seq_mult_signed;

  logic Clock;
  logic Reset;
  int   n_cmp;
  int   n_err;

  seq_mult_signed_if #(.SIZE(16)) m16 ();
  seq_mult_signed_if #(.SIZE(8))  m8 ();

  seq_mult_signed #(.SIZE(16)) u_dut16 (.Clock(Clock), .Reset(Reset), .bus(m16.slave));
  seq_mult_signed #(.SIZE(8))  u_dut8  (.Clock(Clock), .Reset(Reset), .bus(m8.slave));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_mul16(input logic [15:0] a, input logic [15:0] b, input logic s,
                          output logic [31:0] r, output int lat, output int busy_n);
    m16.iMulA = a; m16.iMulB = b; m16.iSigned = s; m16.iStart = 1'b1;
    tick();
    m16.iStart = 1'b0;
    busy_n = m16.oBusy ? 1 : 0;
    lat = 0;
    while (!m16.oDone && lat < 100) begin
      tick();
      lat++;
      if (!m16.oDone && m16.oBusy) busy_n++;
    end
    r = m16.oMulR;
  endtask

  task automatic do_mul8(input logic [7:0] a, input logic [7:0] b, input logic s,
                         output logic [15:0] r, output int lat);
    m8.iMulA = a; m8.iMulB = b; m8.iSigned = s; m8.iStart = 1'b1;
    tick();
    m8.iStart = 1'b0;
    lat = 0;
    while (!m8.oDone && lat < 100) begin
      tick();
      lat++;
    end
    r = m8.oMulR;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    n_cmp += 6;
    if (m16.oBusy !== 1'b0) begin n_err++; $display("FAIL reset_busy16: got %b expected 0", m16.oBusy); end
    if (m16.oDone !== 1'b0) begin n_err++; $display("FAIL reset_done16: got %b expected 0", m16.oDone); end
    if (m16.oMulR !== 32'h0) begin n_err++; $display("FAIL reset_mulr16: got %h expected 0", m16.oMulR); end
    if (m8.oBusy !== 1'b0) begin n_err++; $display("FAIL reset_busy8: got %b expected 0", m8.oBusy); end
    if (m8.oDone !== 1'b0) begin n_err++; $display("FAIL reset_done8: got %b expected 0", m8.oDone); end
    if (m8.oMulR !== 16'h0) begin n_err++; $display("FAIL reset_mulr8: got %h expected 0", m8.oMulR); end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_unsigned16();
    logic [31:0] r;
    int lat, busy_n;
    do_mul16(16'hFFFF, 16'hFFFF, 1'b0, r, lat, busy_n);
    n_cmp += 4;
    if (r !== 32'hFFFE0001) begin n_err++; $display("FAIL u16_result: got %h expected fffe0001", r); end
    if (lat != 17) begin n_err++; $display("FAIL u16_latency: got %0d expected 17", lat); end
    if (busy_n != 17) begin n_err++; $display("FAIL u16_busy_cycles: got %0d expected 17", busy_n); end
    if (m16.oBusy !== 1'b0) begin n_err++; $display("FAIL u16_busy_at_done: got %b expected 0", m16.oBusy); end
    tick();
    n_cmp++;
    if (m16.oDone !== 1'b0) begin n_err++; $display("FAIL u16_done_pulse: got %b expected 0", m16.oDone); end
  endtask

  task automatic test_signed16();
    logic [31:0] r;
    int lat, busy_n;
    do_mul16(16'hFFFD, 16'h0007, 1'b1, r, lat, busy_n);
    n_cmp += 2;
    if (r !== 32'hFFFFFFEB) begin n_err++; $display("FAIL s16_neg3x7: got %h expected ffffffeb", r); end
    if (lat != 17) begin n_err++; $display("FAIL s16_latency: got %0d expected 17", lat); end
    do_mul16(16'hFFFD, 16'h0007, 1'b0, r, lat, busy_n);
    n_cmp++;
    if (r !== 32'h0006FFEB) begin n_err++; $display("FAIL u16_fffdx7: got %h expected 0006ffeb", r); end
  endtask

  task automatic test_signed8();
    logic [15:0] r;
    int lat;
    do_mul8(8'h80, 8'h80, 1'b1, r, lat);
    n_cmp += 2;
    if (r !== 16'h4000) begin n_err++; $display("FAIL s8_min_sq: got %h expected 4000", r); end
    if (lat != 9) begin n_err++; $display("FAIL s8_latency: got %0d expected 9", lat); end
    do_mul8(8'h80, 8'h7F, 1'b1, r, lat);
    n_cmp++;
    if (r !== 16'hC080) begin n_err++; $display("FAIL s8_min_x_max: got %h expected c080", r); end
    do_mul8(8'h00, 8'h80, 1'b1, r, lat);
    n_cmp += 2;
    if (r !== 16'h0000) begin n_err++; $display("FAIL s8_zero: got %h expected 0000", r); end
    if (lat != 9) begin n_err++; $display("FAIL s8_zero_latency: got %0d expected 9", lat); end
  endtask

  task automatic test_back_to_back();
    int lat, lat2, holds_bad;
    m16.iMulA = 16'd3; m16.iMulB = 16'd5; m16.iSigned = 1'b0; m16.iStart = 1'b1;
    tick();
    m16.iMulA = 16'd6; m16.iMulB = 16'd7;
    lat = 0;
    while (!m16.oDone && lat < 100) begin tick(); lat++; end
    n_cmp += 2;
    if (lat != 17) begin n_err++; $display("FAIL b2b_first_latency: got %0d expected 17", lat); end
    if (m16.oMulR !== 32'h0000000F) begin n_err++; $display("FAIL b2b_first_result: got %h expected 0000000f", m16.oMulR); end
    lat2 = 0;
    holds_bad = 0;
    do begin
      tick();
      lat2++;
      if (!m16.oDone && m16.oMulR !== 32'h0000000F) holds_bad++;
    end while (!m16.oDone && lat2 < 100);
    m16.iStart = 1'b0;
    n_cmp += 3;
    if (lat2 != 18) begin n_err++; $display("FAIL b2b_spacing: got %0d expected 18", lat2); end
    if (holds_bad != 0) begin n_err++; $display("FAIL b2b_hold: got %0d changed samples expected 0", holds_bad); end
    if (m16.oMulR !== 32'h0000002A) begin n_err++; $display("FAIL b2b_second_result: got %h expected 0000002a", m16.oMulR); end
    tick();
    n_cmp++;
    if (m16.oDone !== 1'b0 || m16.oBusy !== 1'b0) begin
      n_err++; $display("FAIL b2b_idle: got done=%b busy=%b expected 0 0", m16.oDone, m16.oBusy);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    int lat, busy_n;
    m16.iMulA = 16'h1234; m16.iMulB = 16'h5678; m16.iSigned = 1'b0; m16.iStart = 1'b1;
    tick();
    m16.iStart = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_cmp++;
    if (m16.oBusy !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b expected 1", m16.oBusy); end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    n_cmp += 3;
    if (m16.oBusy !== 1'b0) begin n_err++; $display("FAIL mid_reset_busy: got %b expected 0", m16.oBusy); end
    if (m16.oDone !== 1'b0) begin n_err++; $display("FAIL mid_reset_done: got %b expected 0", m16.oDone); end
    if (m16.oMulR !== 32'h0) begin n_err++; $display("FAIL mid_reset_mulr: got %h expected 0", m16.oMulR); end
    do_mul16(16'd2, 16'd2, 1'b0, r, lat, busy_n);
    n_cmp += 2;
    if (r !== 32'd4) begin n_err++; $display("FAIL mid_restart_result: got %h expected 4", r); end
    if (lat != 17) begin n_err++; $display("FAIL mid_restart_latency: got %0d expected 17", lat); end
  endtask

  task automatic test_random();
    logic [15:0] a16, b16;
    logic [7:0]  a8, b8;
    logic        s;
    logic signed [31:0] sa32, sb32;
    logic signed [15:0] sa16, sb16;
    logic [31:0] r32, e32;
    logic [15:0] r16, e16;
    int lat, busy_n;
    for (int i = 0; i < 150; i++) begin
      a16 = 16'($urandom); b16 = 16'($urandom); s = 1'($urandom_range(0, 1));
      sa32 = $signed(a16); sb32 = $signed(b16);
      e32 = s ? 32'(sa32 * sb32) : ({16'h0, a16} * {16'h0, b16});
      do_mul16(a16, b16, s, r32, lat, busy_n);
      n_cmp++;
      if (r32 !== e32 || lat != 17) begin
        n_err++; $display("FAIL rnd16: a=%h b=%h s=%b got %h lat %0d expected %h lat 17", a16, b16, s, r32, lat, e32);
      end
      a8 = 8'($urandom); b8 = 8'($urandom); s = 1'($urandom_range(0, 1));
      sa16 = $signed(a8); sb16 = $signed(b8);
      e16 = s ? 16'(sa16 * sb16) : ({8'h0, a8} * {8'h0, b8});
      do_mul8(a8, b8, s, r16, lat);
      n_cmp++;
      if (r16 !== e16 || lat != 9) begin
        n_err++; $display("FAIL rnd8: a=%h b=%h s=%b got %h lat %0d expected %h lat 9", a8, b8, s, r16, lat, e16);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    Reset = 1'b1;
    m16.iStart = 1'b0; m16.iSigned = 1'b0; m16.iMulA = 16'h0; m16.iMulB = 16'h0;
    m8.iStart  = 1'b0; m8.iSigned  = 1'b0; m8.iMulA  = 8'h0;  m8.iMulB  = 8'h0;
    test_reset();
    test_unsigned16();
    test_signed16();
    test_signed8();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
